conv_mac_signed: RTL
====================

// Module: conv_mac_signed
// PURPOSE
//  Pipelined multiply-accumulate engine for the 2D convolution datapath.
//  Accepts one (pixel, weight) tap per valid/ready handshake, sums TAPS
//  products per window, and emits one result per window via an output handshake.
//  Successor to the combinational 8x8 signed multiplier: parametrised widths,
//  signed/unsigned mode, window accumulation, optional saturation, backpressure.
// PARAMETERS
//  A_WIDTH    8   pixel operand width
//  B_WIDTH    8   weight operand width
//  TAPS       9   products per window (3x3 kernel); must be >= 1
//  OUT_WIDTH  20  result width
//  SAT_EN     1   1: saturate to OUT_WIDTH range; 0: wrap (keep low OUT_WIDTH bits)
// PORTS
//  clk          in   1          rising-edge clock
//  rst          in   1          synchronous, active-high reset
//  signed_mode  in   1          1: a,b two's complement; 0: a,b unsigned
//  restart      in   1          abort partial window, clear accumulation
//  in_valid     in   1          tap present on a,b
//  in_ready     out  1          engine can take a tap this cycle
//  a            in   A_WIDTH    pixel
//  b            in   B_WIDTH    weight
//  out_valid    out  1          out_data holds a completed window sum
//  out_ready    in   1          consumer takes out_data this cycle
//  out_data     out  OUT_WIDTH  window sum (signed if signed_mode, else unsigned)
//  overflow     out  1          out_data was saturated (SAT_EN=1) or wrapped (SAT_EN=0)
// BEHAVIOUR
//  - Internal width ACC_W = A_WIDTH+B_WIDTH+$clog2(TAPS)+1; no internal overflow.
//  - Operands are extended to ACC_W per signed_mode (sign or zero extension).
//  - Stage 1: product register P (+ valid, last flags) loads on handshake.
//  - Stage 2: accumulator ACC <= last ? 0 : ACC+P; on last, ACC+P goes to the output register.
//  - Tap counter 0..TAPS-1 increments per accepted tap; wraps to 0 after TAPS-1.
//  - Latency: last tap handshake in cycle N -> out_valid=1 with its sum in cycle N+2.
//  - Back-to-back windows need no idle cycles; throughput 1 tap/cycle.
//  - stall = out_valid & ~out_ready. While stalled, P, ACC, counter and output hold.
//    in_ready = ~stall & ~restart (combinational on out_ready).
//  - out_valid holds with stable out_data/overflow until out_ready=1; if a new
//    result arrives in the same cycle out_ready=1, out_valid stays 1 with new data.
//  - Output conversion: SAT_EN=1 clamps to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]
//    (signed) or [0, 2^OUT_WIDTH-1] (unsigned); overflow=1 when clamped.
//    SAT_EN=0 truncates; overflow=1 when the truncated value != the full sum.
//  - If OUT_WIDTH >= ACC_W, the sum is extended per signed_mode and overflow is always 0.
//  - restart=1 (checked before in_valid): counter, ACC and P valid clear next edge.
//    No tap is accepted that cycle. The output register and a pending result are untouched.
//  - signed_mode must be held constant within a window. A change mid-window is undefined.
//  - Reset: in_ready=0 during rst; out_valid=0, out_data=0, overflow=0,
//    counter=0, ACC=0, P valid=0 after the reset edge. Reset mid-window drops it.
// TESTING
//  1 signed, 9 taps a=-128,b=-128 -> out_data=147456, overflow=0 (defaults).
//  2 signed, taps a=1..9, b=-1 streamed continuously, out_ready=1 -> out_data=-45
//    2 cycles after tap 9. A second window follows with no idle cycle.
//  3 OUT_WIDTH=16, SAT_EN=1, 9x(127*127) -> out_data=32767, overflow=1. SAT_EN=0 ->
//    out_data=145161 mod 2^16 = 14089, overflow=1.
//  4 unsigned, 9x(255*255) -> out_data=585225. Same bits in signed mode -> 9.
//  5 hold out_ready=0 with result pending -> in_ready=0, out_data stable. The next window
//    completes only after release. No tap is lost or duplicated.
//  6 restart after 4 taps, then 9 taps of a=2,b=3 -> out_data=54. Assert rst mid-window
//    -> all outputs 0 next cycle and the partial sum is discarded.

Source files
------------

// File: rtl/conv_mac_signed.sv
// Two-stage signed/unsigned multiply-accumulate over TAPS-long windows, one result per window.
// Last tap handshake in cycle N gives out_valid in cycle N+2; a stalled output freezes the whole pipe.
module conv_mac_signed #(
  parameter int A_WIDTH   = 8,
  parameter int B_WIDTH   = 8,
  parameter int TAPS      = 9,
  parameter int OUT_WIDTH = 20,
  parameter bit SAT_EN    = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 signed_mode,
  input  logic                 restart,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [A_WIDTH-1:0]   a,
  input  logic [B_WIDTH-1:0]   b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 overflow
);

  localparam int ACC_W = A_WIDTH + B_WIDTH + $clog2(TAPS) + 1;
  localparam int CNT_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TAPS - 1);

  logic                 stall;
  logic                 accept;
  logic [ACC_W-1:0]     a_ext;
  logic [ACC_W-1:0]     b_ext;
  logic [ACC_W-1:0]     prod;
  logic [ACC_W-1:0]     sum;

  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 p_vld_q, p_vld_d;
  logic                 p_last_q, p_last_d;
  logic                 p_sgn_q, p_sgn_d;
  logic [ACC_W-1:0]     p_q, p_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic                 out_vld_q, out_vld_d;
  logic [OUT_WIDTH-1:0] out_q, out_d;
  logic                 ovf_q, ovf_d;

  logic [OUT_WIDTH-1:0] conv_dat;
  logic                 conv_ovf;

  assign stall    = out_vld_q & ~out_ready;
  assign in_ready = ~rst & ~stall & ~restart;
  assign accept   = in_valid & in_ready;

  // Low ACC_W bits of the product are identical for signed and unsigned
  // interpretation once both operands are extended to ACC_W.
  assign a_ext = {{(ACC_W - A_WIDTH){signed_mode & a[A_WIDTH-1]}}, a};
  assign b_ext = {{(ACC_W - B_WIDTH){signed_mode & b[B_WIDTH-1]}}, b};
  assign prod  = a_ext * b_ext;
  assign sum   = acc_q + p_q;

  always_comb begin
    cnt_d    = cnt_q;
    p_vld_d  = p_vld_q;
    p_last_d = p_last_q;
    p_sgn_d  = p_sgn_q;
    p_d      = p_q;
    if (restart) begin
      cnt_d   = '0;
      p_vld_d = 1'b0;
    end else if (!stall) begin
      p_vld_d = accept;
      if (accept) begin
        p_d      = prod;
        p_last_d = (cnt_q == LAST_CNT);
        p_sgn_d  = signed_mode;
        cnt_d    = (cnt_q == LAST_CNT) ? '0 : cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    acc_d     = acc_q;
    out_vld_d = out_vld_q;
    out_d     = out_q;
    ovf_d     = ovf_q;
    if (out_vld_q && out_ready) begin
      out_vld_d = 1'b0;
    end
    if (restart) begin
      acc_d = '0;
    end else if (!stall && p_vld_q) begin
      if (p_last_q) begin
        acc_d     = '0;
        out_vld_d = 1'b1;
        out_d     = conv_dat;
        ovf_d     = conv_ovf;
      end else begin
        acc_d = sum;
      end
    end
  end

  // The mode travels with the product so a mode change right after a
  // window's last tap cannot affect that window's output conversion.
  generate
    if (OUT_WIDTH >= ACC_W) begin : g_wide
      always_comb begin
        conv_ovf = 1'b0;
        if (p_sgn_q) begin
          conv_dat = OUT_WIDTH'($signed(sum));
        end else begin
          conv_dat = OUT_WIDTH'(sum);
        end
      end
    end else begin : g_narrow
      logic                 hi_ovf;
      logic [OUT_WIDTH-1:0] sat_val;
      always_comb begin
        if (p_sgn_q) begin
          hi_ovf  = ~((&sum[ACC_W-1:OUT_WIDTH-1]) | ~(|sum[ACC_W-1:OUT_WIDTH-1]));
          sat_val = sum[ACC_W-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                 : {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end else begin
          hi_ovf  = |sum[ACC_W-1:OUT_WIDTH];
          sat_val = '1;
        end
        conv_ovf = hi_ovf;
        conv_dat = (SAT_EN && hi_ovf) ? sat_val : sum[OUT_WIDTH-1:0];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      p_vld_q   <= 1'b0;
      p_last_q  <= 1'b0;
      p_sgn_q   <= 1'b0;
      p_q       <= '0;
      acc_q     <= '0;
      out_vld_q <= 1'b0;
      out_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      p_vld_q   <= p_vld_d;
      p_last_q  <= p_last_d;
      p_sgn_q   <= p_sgn_d;
      p_q       <= p_d;
      acc_q     <= acc_d;
      out_vld_q <= out_vld_d;
      out_q     <= out_d;
      ovf_q     <= ovf_d;
    end
  end

  assign out_valid = out_vld_q;
  assign out_data  = out_q;
  assign overflow  = ovf_q;

endmodule
